bram_stream_rd: RTL and testbench
=================================

# bram_stream_rd

Upstream read stage of the realignment path. Accepts a row-range command, streams 1536-bit rows (24 lanes × 64 bit) out of a synchronous BRAM, and presents them to `interface_in` with the `s_first`/`s_last` lane offsets and per-lane `s_tlast` that stage expects. Absorbs BRAM read latency with a credit-controlled prefetch FIFO so `m_tready` backpressure never loses data and a held-high `m_tready` gives one row per cycle.

## Interface
- `ADDR_W`, 12, BRAM row address width
- `LEN_W`, 12, row-count width
- `RD_LAT`, 2, BRAM read latency in cycles (≥1)
- `FIFO_DEPTH`, 4, prefetch FIFO entries; ≥ RD_LAT+2 required for full throughput

- `clk` in 1 — single clock
- `rst` in 1 — synchronous, active-high reset
- `cmd_valid` in 1 — command request
- `cmd_ready` out 1 — high only in IDLE
- `cmd_addr` in ADDR_W — first BRAM row
- `cmd_rows` in LEN_W — rows to read; 0 = empty transfer
- `cmd_first` in 6 — lane offset for realignment, 0..23
- `cmd_last` in 6 — valid lanes in final row, 1..24
- `bram_en` out 1 — read enable
- `bram_addr` out ADDR_W — read row
- `bram_dout` in 1536 — read data, valid RD_LAT cycles after `bram_en`
- `m_tdata` out 1536 — row data, lane 0 at bits [63:0]
- `m_tvalid` out 1; `m_tready` in 1 — AXI-S handshake
- `m_tkeep` out 16 — constant 16'hffff
- `m_tlast` out 24 — one-hot at lane `cmd_last-1` on the final row, else 0
- `m_first`, `m_last` out 6 — latched `cmd_first`/`cmd_last`, stable for the whole transfer
- `busy` out 1 — high from command acceptance to `done`
- `done` out 1 — one-cycle pulse when the transfer completes

## Operation
- FSM IDLE → ISSUE → DRAIN → IDLE.
- IDLE: `cmd_ready`=1. On `cmd_valid`: latch addr, rows, first, last. Go to ISSUE, or to DRAIN if `cmd_rows`=0.
- Clamping at latch: `cmd_first`>23 → 23. `cmd_last`=0 or >24 → 24.
- ISSUE: assert `bram_en` when `inflight + fifo_count < FIFO_DEPTH`. Each issue increments the address and decrements the remaining count. Last issue → DRAIN.
- Read tag pipe: RD_LAT-deep shift register of {valid, is_last}. When a valid tag emerges, write `bram_dout` plus is_last into the FIFO. `inflight` counts issued reads not yet written.
- Credit accounting prevents FIFO overflow. Same-cycle issue, FIFO write and FIFO read must all be counted correctly.
- Output: FIFO head drives `m_tdata`/`m_tvalid`. `m_tlast` = is_last ? (1<<(m_last-1)) : 0. Pop on `m_tvalid & m_tready`.
- DRAIN: when `inflight`=0, the FIFO is empty and the last row has handshaked (or rows=0), pulse `done` and return to IDLE.
- `bram_addr` wraps modulo 2^ADDR_W.

## Timing
- Reset values: `cmd_ready`=0 during `rst`, 1 on the first cycle after. `bram_en`=0, `bram_addr`=0, `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0, `m_first`=0, `m_last`=0, `busy`=0, `done`=0.
- Command accepted at cycle T → first `bram_en` at T+1 → first `m_tvalid` at T+2+RD_LAT.
- Throughput: 1 row/cycle with `m_tready` held high and FIFO_DEPTH ≥ RD_LAT+2.
- `m_tvalid` must not drop and `m_tdata` must not change while `m_tvalid & ~m_tready`.
- `done` fires the cycle after the final handshake. `cmd_ready` rises the cycle after `done`.
- rows=0: `done` at T+1; no `bram_en`, no `m_tvalid`.
- `rst` mid-transfer: next cycle all state returns to reset values and in-flight reads are discarded. No `done` is emitted.
- `m_first`/`m_last` update only on command acceptance.

## Structure
- Shared package `bram_stream_pkg`:
  - `LANES`=24, `LANE_W`=64, `DATA_W`=1536
  - lane-offset width 6
  - FSM state enum {IDLE, ISSUE, DRAIN}
- Sub-module `stream_fifo`: synchronous FIFO, parameterised width/depth, exposing `count`. Entry width is DATA_W+1 (data plus is_last).

## Test plan
- addr=0x010, rows=3, first=5, last=7, `m_tready`=1 → rows 0x010..0x012 on consecutive cycles from T+4 (RD_LAT=2). `m_tlast`=0x000040 only on the third row. `m_first`=5, `m_last`=7. `done` pulses once.
- rows=8, `m_tready` toggling 1-0-1-0 → all 8 rows in order, no drops or duplicates. `m_tdata` stable while stalled. Credit accounting keeps `inflight + count` ≤ 4.
- rows=0 → `done` at T+1; zero `bram_en` and zero `m_tvalid` cycles.
- addr=0xFFE, rows=4 → reads 0xFFE, 0xFFF, 0x000, 0x001.
- `rst` asserted 2 cycles into a rows=6 transfer with `m_tready`=0 → all outputs at reset values next cycle. A following rows=1 command behaves normally.
- first=30, last=0 → `m_first`=23, `m_last`=24, `m_tlast`=0x800000 on the final row.

Source files
------------

// File: rtl/bram_stream_rd_pkg.sv
// Shared constants, FSM encoding and command clamping helpers
// for the BRAM row streaming read stage.
package bram_stream_pkg;

    localparam int LANES  = 24;
    localparam int LANE_W = 64;
    localparam int DATA_W = LANES * LANE_W;
    localparam int OFF_W  = 6;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    function automatic logic [OFF_W-1:0] clamp_first(
        input logic [OFF_W-1:0] f
    );
        return (f > 6'd23) ? 6'd23 : f;
    endfunction

    function automatic logic [OFF_W-1:0] clamp_last(
        input logic [OFF_W-1:0] l
    );
        return ((l == '0) || (l > 6'd24)) ? 6'd24 : l;
    endfunction

endpackage

// File: rtl/bram_stream_rd_fifo.sv
// Synchronous FIFO with occupancy count; the caller guarantees
// it never writes when full nor reads when empty.
module stream_fifo
    import bram_stream_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    w_wp_nxt;
    logic [AW-1:0]    w_rp_nxt;

    assign w_wp_nxt = (r_wp == AW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
    assign w_rp_nxt = (r_rp == AW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (i_wr_en) r_wp <= w_wp_nxt;
            if (i_rd_en) r_rp <= w_rp_nxt;
            unique case ({i_wr_en, i_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[r_wp] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rp];
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;

endmodule

// File: rtl/bram_stream_rd.sv
// Streams a row range out of a synchronous BRAM into interface_in,
// hiding read latency behind a credit-limited prefetch FIFO.
module bram_stream_rd
    import bram_stream_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int LEN_W      = 12,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_rows,
    input  logic [OFF_W-1:0]  cmd_first,
    input  logic [OFF_W-1:0]  cmd_last,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [15:0]       m_tkeep,
    output logic [LANES-1:0]  m_tlast,
    output logic [OFF_W-1:0]  m_first,
    output logic [OFF_W-1:0]  m_last,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_rows;
    logic [OFF_W-1:0]    r_first;
    logic [OFF_W-1:0]    r_last;
    logic [CW-1:0]       r_inflight;
    logic [RD_LAT-1:0]   r_tag_v;
    logic [RD_LAT-1:0]   r_tag_last;

    logic                w_accept;
    logic                w_credit;
    logic [CW:0]         w_used;
    logic                w_wr;
    logic                w_pop;
    logic                w_empty;
    logic [CW-1:0]       w_count;
    logic [DATA_W:0]     w_head;

    // Rows issued but not yet popped must fit in the FIFO.
    assign w_used   = {1'b0, r_inflight} + {1'b0, w_count};
    assign w_credit = (w_used < {1'b0, DEPTH_C});
    assign w_accept = cmd_valid & cmd_ready;
    assign w_wr     = r_tag_v[RD_LAT-1];
    assign w_pop    = m_tvalid & m_tready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        bram_en   = 1'b0;
        done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                cmd_ready = ~rst;
                if (cmd_valid) begin
                    w_next = (cmd_rows == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                bram_en = w_credit;
                if (w_credit && (r_rows == LEN_W'(1))) w_next = DRAIN;
            end
            DRAIN: begin
                if ((r_inflight == '0) && w_empty) begin
                    done   = ~rst;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_rows     <= '0;
            r_first    <= '0;
            r_last     <= '0;
            r_inflight <= '0;
            r_tag_v    <= '0;
            r_tag_last <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= cmd_addr;
                r_rows  <= cmd_rows;
                r_first <= clamp_first(cmd_first);
                r_last  <= clamp_last(cmd_last);
            end else if (bram_en) begin
                r_addr <= r_addr + 1'b1;
                r_rows <= r_rows - 1'b1;
            end
            r_tag_v[0]    <= bram_en;
            r_tag_last[0] <= (r_rows == LEN_W'(1));
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_v[i]    <= r_tag_v[i-1];
                r_tag_last[i] <= r_tag_last[i-1];
            end
            unique case ({bram_en, w_wr})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    stream_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr),
        .i_wr_data ({r_tag_last[RD_LAT-1], bram_dout}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    assign bram_addr = r_addr;
    assign m_tvalid  = ~w_empty;
    assign m_tdata   = m_tvalid ? w_head[DATA_W-1:0] : '0;
    assign m_tlast   = (m_tvalid && w_head[DATA_W])
                     ? (LANES'(1) << (r_last - 6'd1)) : '0;
    assign m_tkeep   = 16'hffff;
    assign m_first   = r_first;
    assign m_last    = r_last;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_bram_stream_rd.sv
// Directed and randomized checks of bram_stream_rd against a
// row-list reference model and a latency-modelled BRAM.
module tb_bram_stream_rd;

    localparam int RD_LAT = 2;
    localparam int DEPTH  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [11:0]   cmd_addr = '0;
    logic [11:0]   cmd_rows = '0;
    logic [5:0]    cmd_first = '0;
    logic [5:0]    cmd_last = '0;
    logic          bram_en;
    logic [11:0]   bram_addr;
    logic [1535:0] bram_dout;
    logic [1535:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic [15:0]   m_tkeep;
    logic [23:0]   m_tlast;
    logic [5:0]    m_first;
    logic [5:0]    m_last;
    logic          busy;
    logic          done;

    bram_stream_rd #(
        .ADDR_W(12), .LEN_W(12), .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_rows(cmd_rows),
        .cmd_first(cmd_first), .cmd_last(cmd_last),
        .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_first(m_first), .m_last(m_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int unsigned salt;

    int en_total, hs_total, en_cnt, valid_cnt, beats;
    int first_en, first_v, first_hs, last_hs;
    int done_cnt, done_cyc, acc_cyc, exp_total;
    int exp_first, exp_last;
    bit acc_seen;
    logic done_rdy;
    logic stall_prev = 1'b0;
    logic [1535:0] stall_data;
    logic [11:0]   addr_q [$];
    logic [1535:0] exp_d [$];
    logic [23:0]   exp_l [$];

    function automatic logic [1535:0] row_data(input logic [11:0] a);
        logic [1535:0] r;
        logic [31:0] h;
        h = salt ^ ({20'h0, a} * 32'h9e3779b9);
        for (int i = 0; i < 24; i++) r[i*64 +: 64] = {h, 16'(i), 4'h0, a};
        return r;
    endfunction

    // BRAM: data for a read enabled in cycle c appears in cycle c+RD_LAT
    logic [1535:0] rd_p [RD_LAT];
    always @(posedge clk) begin
        rd_p[0] <= bram_en ? row_data(bram_addr) : '0;
        for (int i = 1; i < RD_LAT; i++) rd_p[i] <= rd_p[i-1];
    end
    assign bram_dout = rd_p[RD_LAT-1];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_row(input string tag, input logic [1535:0] obs,
                           input logic [1535:0] exp);
        int ln = 0;
        for (int i = 23; i >= 0; i--)
            if (obs[i*64 +: 64] !== exp[i*64 +: 64]) ln = i;
        chk(tag, obs[ln*64 +: 64], exp[ln*64 +: 64]);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            en_total   = 0;
            hs_total   = 0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                acc_seen = 1'b1; acc_cyc = cyc;
                en_cnt = 0; valid_cnt = 0; beats = 0;
                first_en = -1; first_v = -1; first_hs = -1; last_hs = -1;
                done_cnt = 0; done_cyc = -1;
                addr_q.delete();
            end
            chk("credit_limit",
                64'((en_total - hs_total + int'(bram_en)) <= DEPTH), 1);
            if (bram_en) begin
                en_cnt++; en_total++;
                if (first_en < 0) first_en = cyc;
                addr_q.push_back(bram_addr);
            end
            if (stall_prev) begin
                chk("stall_valid", m_tvalid, 1);
                chk_row("stall_data", m_tdata, stall_data);
            end
            if (m_tvalid) begin
                valid_cnt++;
                if (first_v < 0) first_v = cyc;
            end
            if (m_tvalid && m_tready) begin
                hs_total++; beats++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                chk("tkeep", m_tkeep, 16'hffff);
                if (exp_d.size() == 0) begin
                    chk("beat_count_overrun", beats, exp_total);
                end else begin
                    chk_row("row_data", m_tdata, exp_d.pop_front());
                    chk("tlast", m_tlast, exp_l.pop_front());
                end
            end
            stall_prev = m_tvalid && !m_tready;
            stall_data = m_tdata;
            if (done) begin
                done_cnt++; done_cyc = cyc; done_rdy = cmd_ready;
            end
        end
    end

    task automatic drive_ready(input int mode);
        case (mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            2:       m_tready = ($urandom_range(0, 3) != 0);
            default: m_tready = 1'b0;
        endcase
    endtask

    task automatic send_cmd(input logic [11:0] a, input logic [11:0] n,
                            input logic [5:0] f, input logic [5:0] l);
        logic [23:0] tl;
        exp_first = (f > 23) ? 23 : int'(f);
        exp_last  = (l == 0 || l > 24) ? 24 : int'(l);
        exp_total = int'(n);
        exp_d.delete(); exp_l.delete();
        for (int k = 0; k < int'(n); k++) begin
            tl = '0;
            if (k == int'(n) - 1) tl[exp_last-1] = 1'b1;
            exp_d.push_back(row_data(a + 12'(k)));
            exp_l.push_back(tl);
        end
        acc_seen = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = a; cmd_rows = n;
        cmd_first = f; cmd_last = l;
        for (int i = 0; i < 20 && !acc_seen; i++) @(posedge clk);
        #1 cmd_valid = 1'b0;
        chk("cmd_accepted", acc_seen, 1);
    endtask

    task automatic wait_done(input int mode);
        int n = 0;
        while (done_cnt == 0 && n < 400) begin
            @(posedge clk); #1;
            drive_ready(mode);
            n++;
        end
        chk("done_seen", done_cnt, 1);
        @(negedge clk);
        chk("cmd_ready_after_done", cmd_ready, 1);
        chk("cmd_ready_low_at_done", done_rdy, 0);
        chk("done_timing", done_cyc,
            (exp_total == 0) ? acc_cyc + 1 : last_hs + 1);
        chk("beats", beats, exp_total);
        chk("exp_drained", exp_d.size(), 0);
        chk("m_first", m_first, exp_first);
        chk("m_last", m_last, exp_last);
        repeat (2) @(negedge clk);
        chk("single_done", done_cnt, 1);
    endtask

    task automatic chk_reset();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_bram_en", bram_en, 0);
        chk("rst_bram_addr", bram_addr, 0);
        chk("rst_tvalid", m_tvalid, 0);
        chk_row("rst_tdata", m_tdata, '0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_m_first", m_first, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] wa;
        salt = $urandom;
        repeat (3) @(posedge clk);
        @(negedge clk) chk("cmd_ready_in_rst", cmd_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_reset();

        m_tready = 1'b1;
        send_cmd(12'h010, 12'd3, 6'd5, 6'd7);
        wait_done(0);
        chk("t1_first_en_lat", first_en - acc_cyc, 1);
        chk("t1_first_valid_lat", first_v - acc_cyc, RD_LAT + 2);
        chk("t1_back_to_back", last_hs - first_hs, 2);
        chk("t1_en_cnt", en_cnt, 3);
        for (int k = 0; k < 3; k++) begin
            wa = 12'h010 + 12'(k);
            chk("t1_addr", addr_q[k], wa);
        end

        m_tready = 1'b1;
        send_cmd(12'($urandom), 12'd8, 6'($urandom), 6'($urandom));
        wait_done(1);
        chk("t2_en_cnt", en_cnt, 8);

        send_cmd(12'($urandom), 12'd0, 6'd3, 6'd4);
        wait_done(0);
        chk("t3_no_bram_en", en_cnt, 0);
        chk("t3_no_tvalid", valid_cnt, 0);

        send_cmd(12'hFFE, 12'd4, 6'd0, 6'd24);
        wait_done(2);
        chk("t4_en_cnt", addr_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            wa = 12'hFFE + 12'(k);
            chk("t4_wrap_addr", addr_q[k], wa);
        end

        m_tready = 1'b0;
        send_cmd(12'($urandom), 12'd6, 6'd1, 6'd2);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk) chk("t5_cmd_ready_in_rst", cmd_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_reset();
        exp_d.delete(); exp_l.delete();
        repeat (6) @(negedge clk);
        chk("t5_no_done", done_cnt, 0);
        chk("t5_no_tvalid", valid_cnt, 0);
        m_tready = 1'b1;
        send_cmd(12'($urandom), 12'd1, 6'd0, 6'd1);
        wait_done(0);

        send_cmd(12'($urandom), 12'd2, 6'd30, 6'd0);
        wait_done(0);

        repeat (12) begin
            send_cmd(12'($urandom), 12'($urandom_range(0, 10)),
                     6'($urandom), 6'($urandom));
            wait_done($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
